fetch_stage: RTL



---
 rtl/fetch_stage.sv | 131 +++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// fetch_stage
// Instruction-fetch stage: owns the program counter, addresses the
// combinational instruction ROM and captures the returned word into the
// IF/ID pipeline register. Handles stall, redirect and halt.
//
// Optional feature macro: FETCH_FAULT_EN
//   When defined, a fetch from a misaligned address or from outside the
//   ROM window parks the stage in FAULT until a redirect to a legal target.
//   When undefined, no address check is made and fetch_fault_o is 0.
//
// state   | meaning
// --------+-----------------------------------------------------------
// RUN     | normal fetch; redirect > halt > stall > advance
// HALTED  | halt seen; PC frozen, IF/ID invalid, only reset leaves
// FAULT   | illegal fetch address; waits for a legal redirect (macro only)

module fetch_stage #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000,
    parameter logic [31:0] ROM_BASE     = 32'hBFC0_0000,
    parameter int unsigned ROM_BYTES    = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_target_i,
    input  logic        halt_i,
    input  logic [31:0] instr_i,
    output logic [31:0] pc_o,
    output logic [31:0] if_id_instr_o,
    output logic [31:0] if_id_pc_o,
    output logic [31:0] if_id_pc_plus4_o,
    output logic        if_id_valid_o,
    output logic        halted_o,
    output logic        fetch_fault_o,
    output logic [31:0] fetch_count_o
);

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] ROM_LAST  = ROM_BASE + 32'(ROM_BYTES) - 32'd1;

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_HALTED = 2'b01,
        ST_FAULT  = 2'b10
    } state_t;

    state_t      state;
    logic [31:0] pc_plus4;
    logic        pc_legal;
    logic        target_legal;

    // Word-aligned and inside the ROM window.
    function automatic logic fetch_addr_legal(input logic [31:0] addr);
        return (addr[1:0] == 2'b00) && (addr >= ROM_BASE) && (addr <= ROM_LAST);
    endfunction

    // Next sequential address and legality of both candidate fetch addresses.
    always_comb begin
        pc_plus4     = pc_o + 32'd4;
        pc_legal     = fetch_addr_legal(pc_o);
        target_legal = fetch_addr_legal(redirect_target_i);
    end

    // Fetch FSM together with the PC, IF/ID register and fetch counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= ST_RUN;
            pc_o             <= RESET_VECTOR;
            if_id_instr_o    <= NOP_INSTR;
            if_id_pc_o       <= 32'h0000_0000;
            if_id_pc_plus4_o <= 32'h0000_0004;
            if_id_valid_o    <= 1'b0;
            fetch_count_o    <= 32'h0000_0000;
        end else begin
            case (state)
                ST_RUN: begin
                    if (redirect_i) begin
                        // Wrong-path word is dropped even when stalled.
                        pc_o          <= redirect_target_i;
                        if_id_valid_o <= 1'b0;
`ifdef FETCH_FAULT_EN
                    end else if (!pc_legal) begin
                        state         <= ST_FAULT;
                        if_id_valid_o <= 1'b0;
`endif
                    end else if (halt_i) begin
                        state         <= ST_HALTED;
                        if_id_valid_o <= 1'b0;
                    end else if (!stall_i) begin
                        if_id_instr_o    <= instr_i;
                        if_id_pc_o       <= pc_o;
                        if_id_pc_plus4_o <= pc_plus4;
                        if_id_valid_o    <= 1'b1;
                        pc_o             <= pc_plus4;
                        fetch_count_o    <= fetch_count_o + 32'd1;
                    end
                end
                ST_HALTED: begin
                    if_id_valid_o <= 1'b0;
                end
`ifdef FETCH_FAULT_EN
                ST_FAULT: begin
                    if_id_valid_o <= 1'b0;
                    // An illegal target leaves the PC where it faulted.
                    if (redirect_i && target_legal) begin
                        state <= ST_RUN;
                        pc_o  <= redirect_target_i;
                    end
                end
`endif
                default: begin
                    state         <= ST_RUN;
                    if_id_valid_o <= 1'b0;
                end
            endcase
        end
    end

    assign halted_o = (state == ST_HALTED);

`ifdef FETCH_FAULT_EN
    assign fetch_fault_o = (state == ST_FAULT);
`else
    // Address checks exist but have no consumer without the fault feature.
    logic unused_fault_chk;
    assign unused_fault_chk = pc_legal ^ target_legal;
    assign fetch_fault_o    = 1'b0;
`endif

endmodule
